// File: rtl/wish_pack_var.sv
// wish_pack_var
//   Wishbone-style word packer. Collects 1..MAX_PACK narrow source words
//   (count chosen at runtime by cfg_pack_i) into one wide destination word.
//   A source flush closes the pack early. In that case d_sel_o and d_cnt_o
//   describe the partial pack.
//   The destination side has a one-deep output register. While it holds an
//   unacknowledged pack, the source can keep filling the accumulator. Only
//   the word that would close the next pack is stalled.
//
// Handshake: a source word transfers on every clock edge where s_ack_o=1.
//   s_ack_o is s_stb_i & s_cyc_i with no stall. A pack on the destination
//   side is presented with d_stb_o=d_cyc_o=1. It holds steady until
//   d_ack_i=1 is sampled on an edge.
//
// Ports:
//   clk_i, rst_i       clock, async active-high reset
//   cfg_pack_i         words per pack (0 or >MAX_PACK means MAX_PACK)
//   s_stb_i, s_cyc_i   source strobe / cycle
//   s_ack_o, s_stall_o source accept / hold (combinational)
//   s_dat_i, s_tgc_i   source word and tag
//   s_flush_i          this word ends the packet
//   d_stb_o, d_cyc_o   destination strobe / cycle (registered)
//   d_ack_i            destination accepts the pack
//   d_dat_o            packed data, unfilled slots zero
//   d_sel_o            slot-valid mask
//   d_cnt_o            number of valid words
//   d_tgc_o            OR of the tags of all packed words
module wish_pack_var #(
  parameter int DATA_WIDTH    = 8,
  parameter int MAX_PACK      = 4,
  parameter int TGC_WIDTH     = 2,
  parameter int LITTLE_ENDIAN = 1,
  localparam int CW = $clog2(MAX_PACK + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [CW-1:0]                  cfg_pack_i,
  input  logic                           s_stb_i,
  input  logic                           s_cyc_i,
  output logic                           s_ack_o,
  output logic                           s_stall_o,
  input  logic [DATA_WIDTH-1:0]          s_dat_i,
  input  logic [TGC_WIDTH-1:0]           s_tgc_i,
  input  logic                           s_flush_i,
  output logic                           d_stb_o,
  output logic                           d_cyc_o,
  input  logic                           d_ack_i,
  output logic [DATA_WIDTH*MAX_PACK-1:0] d_dat_o,
  output logic [MAX_PACK-1:0]            d_sel_o,
  output logic [CW-1:0]                  d_cnt_o,
  output logic [TGC_WIDTH-1:0]           d_tgc_o
);

  localparam int PW = DATA_WIDTH * MAX_PACK;

  // Accumulator state
  logic [PW-1:0]        acc_buf;
  logic [CW-1:0]        acc_cnt;
  logic [TGC_WIDTH-1:0] acc_tgc;
  logic [CW-1:0]        pk;

  logic [CW-1:0]        cfg_clamped;
  logic [CW-1:0]        pk_eff;
  logic [CW-1:0]        cnt_inc;
  logic [CW-1:0]        slot;
  logic [CW-1:0]        sel_lo;
  logic [CW-1:0]        sel_hi;
  logic                 req;
  logic                 closes;
  logic [PW-1:0]        merged;
  logic [MAX_PACK-1:0]  sel_next;

  always_comb begin
    if (cfg_pack_i == '0 || cfg_pack_i > CW'(MAX_PACK)) cfg_clamped = CW'(MAX_PACK);
    else                                                 cfg_clamped = cfg_pack_i;

    // An empty accumulator follows the live configuration. Once a pack is
    // started, its size stays frozen in pk.
    pk_eff  = (acc_cnt == '0) ? cfg_clamped : pk;
    cnt_inc = acc_cnt + CW'(1);
    req     = s_stb_i & s_cyc_i & ~rst_i;
    closes  = (cnt_inc == pk_eff) | s_flush_i;

    // Big-endian fills from the top of the pk-slot window downward.
    // The occupied slots of a partial pack are therefore the window's top slots.
    slot    = (LITTLE_ENDIAN != 0) ? acc_cnt : (pk_eff - CW'(1) - acc_cnt);
    sel_lo  = (LITTLE_ENDIAN != 0) ? '0      : slot;
    sel_hi  = (LITTLE_ENDIAN != 0) ? acc_cnt : (pk_eff - CW'(1));

    merged   = acc_buf;
    sel_next = '0;
    for (int i = 0; i < MAX_PACK; i++) begin
      if (slot == CW'(i)) merged[i*DATA_WIDTH +: DATA_WIDTH] = s_dat_i;
      sel_next[i] = (CW'(i) >= sel_lo) && (CW'(i) <= sel_hi);
    end
  end

  // Only a closing word needs the output register, so only it can be stalled.
  assign s_stall_o = d_stb_o & ~d_ack_i & closes;
  assign s_ack_o   = req & ~s_stall_o;
  assign d_cyc_o   = d_stb_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_buf <= '0;
      acc_cnt <= '0;
      acc_tgc <= '0;
      pk      <= CW'(MAX_PACK);
      d_stb_o <= 1'b0;
      d_dat_o <= '0;
      d_sel_o <= '0;
      d_cnt_o <= '0;
      d_tgc_o <= '0;
    end else begin
      if (acc_cnt == '0) pk <= cfg_clamped;

      if (d_stb_o && d_ack_i) d_stb_o <= 1'b0;

      if (s_ack_o) begin
        if (closes) begin
          // A closing accept implies that the output register is free or is
          // being acknowledged now. A back-to-back load overrides the drop above.
          d_dat_o <= merged;
          d_sel_o <= sel_next;
          d_cnt_o <= cnt_inc;
          d_tgc_o <= acc_tgc | s_tgc_i;
          d_stb_o <= 1'b1;
          acc_buf <= '0;
          acc_cnt <= '0;
          acc_tgc <= '0;
        end else begin
          acc_buf <= merged;
          acc_cnt <= cnt_inc;
          acc_tgc <= acc_tgc | s_tgc_i;
        end
      end
    end
  end

endmodule
